cap_bank_sched: RTL and testbench
=================================

Name: cap_bank_sched

Overview:
- Frame-bank write scheduler in the camera pixel-clock domain.
- Sits between image_capture and the four 320x240 frame-buffer RAMs.
- Steers capture writes into one bank at a time, counts and validates each frame, and rotates banks round-robin on every complete frame.
- Publishes the last complete bank as a one-hot display selection; the VGA side synchronises it separately.

Parameters:
NUM_BANKS, 4, number of frame banks; one-hot width of the bank vectors
FRAME_PIXELS, 76800, pixels in one complete frame (320x240)
ADDRW, 17, pixel address and pixel counter width
FCNT_W, 8, committed-frame counter width

Ports:
cap_pclk  input  1  sole clock, camera pixel clock
cap_rst  input  1  reset; synchronous to cap_pclk, active-high
en  input  1  level; capture enable
single_shot  input  1  pulse; capture exactly one frame, then stop
cap_vsync  input  1  camera vsync; high during vertical blanking
cap_we  input  1  pixel write strobe from image_capture
cap_addr  input  ADDRW  pixel address from image_capture
bank_we  output  NUM_BANKS  per-bank write enables to the frame RAMs
wr_bank  output  NUM_BANKS  one-hot bank currently being written
disp_bank  output  NUM_BANKS  one-hot last committed bank; 0 = none yet
disp_valid  output  1  at least one frame committed
frame_done  output  1  1-cycle pulse when a frame is committed
frame_err  output  1  1-cycle pulse when a frame is rejected
pix_cnt  output  ADDRW  accepted writes in the current frame
frame_cnt  output  FCNT_W  committed frames, wraps
busy  output  1  high in WAIT_VS, ACTIVE and COMMIT

Behaviour:
- Interface: one clock, cap_pclk; reset cap_rst is synchronous and active-high. cap_rst at any time, including mid-frame, applies the reset values below on the next edge.
- Reset values:
  - state IDLE
  - wr_bank = 0001, disp_bank = 0000
  - disp_valid, frame_done, frame_err, busy = 0
  - pix_cnt = 0, frame_cnt = 0
  - vsync_d = 1, ss_latch = 0
- Edge detection:
  - vsync_d is cap_vsync registered.
  - Falling edge (vs_fall) = vsync_d & ~cap_vsync; rising edge (vs_rise) = ~vsync_d & cap_vsync.
- bank_we is combinational, zero latency:
  - bank_we = wr_bank when state = ACTIVE, cap_we = 1 and pix_cnt < FRAME_PIXELS; otherwise 0.
  - This keeps the RAM write aligned with cap_addr and the pixel data.
- State IDLE:
  - en = 1 -> WAIT_VS.
  - ss_latch is set by single_shot in IDLE or WAIT_VS.
- State WAIT_VS:
  - en = 0 -> IDLE.
  - vs_fall -> ACTIVE, with pix_cnt cleared and addr_ok set to 1.
- State ACTIVE:
  - Each accepted write increments pix_cnt. pix_cnt saturates at FRAME_PIXELS; further writes are blocked and clear addr_ok.
  - An accepted write whose cap_addr != pix_cnt clears addr_ok.
  - en going low does not abort; the frame runs to completion.
  - On vs_rise, evaluate with the pix_cnt value that includes any write accepted in the same cycle:
    - count = FRAME_PIXELS and addr_ok = 1 -> COMMIT.
    - Otherwise pulse frame_err, keep wr_bank, and go to WAIT_VS (or to IDLE if en = 0 or ss_latch = 1). The same bank is reused and the display is never touched.
- State COMMIT (exactly 1 cycle):
  - disp_bank <= wr_bank, disp_valid <= 1, frame_done pulse, frame_cnt++ (wraps to 0).
  - wr_bank rotates left by one, 1000 -> 0001.
  - Next state is IDLE if ss_latch = 1 or en = 0 (ss_latch cleared); otherwise WAIT_VS.
  - A vs_fall during COMMIT is missed; the next frame starts on the following vs_fall.
- Invariant: wr_bank != disp_bank whenever bank_we != 0 (NUM_BANKS >= 2).
- Timing of frame_done and frame_err:
  - frame_done is registered and asserts the cycle after COMMIT is entered.
  - frame_err is registered and asserts the cycle after the vs_rise evaluation.
  - frame_done and frame_err are never high together.

Test Plan:
1. Reset, en = 1, vsync 1->0, 76800 writes with cap_addr 0..76799, vsync 0->1 -> bank_we = 0001 throughout; one frame_done; disp_bank = 0001; wr_bank = 0010; frame_cnt = 1.
2. Five good frames back-to-back -> disp_bank sequence 0001, 0010, 0100, 1000, 0001; frame_cnt = 5; bank_we never equal to disp_bank.
3. Short frame of 1000 writes, then vsync rise -> frame_err pulse; disp_bank and wr_bank unchanged; next good frame commits into the same bank.
4. 76810 writes -> last 10 writes have bank_we = 0; pix_cnt = 76800; frame_err at vsync rise. Separately, a good-length frame with a duplicated cap_addr -> frame_err.
5. single_shot pulse in IDLE, then en = 1, then two frames -> one frame_done; return to IDLE; busy = 0; second frame ignored.
6. cap_rst asserted at pix_cnt = 40000 -> next edge: all outputs at reset values, disp_valid = 0; a fresh frame commits to bank 0001.

Source files
------------

// File: rtl/cap_bank_sched.sv
// cap_bank_sched: steers camera writes into one frame bank at a time, validates each frame
// and rotates banks round-robin, publishing the last complete bank for display.
module cap_bank_sched #(
    parameter int NUM_BANKS    = 4,
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDRW        = 17,
    parameter int FCNT_W       = 8
) (
    input  logic                 cap_pclk,
    input  logic                 cap_rst,
    input  logic                 en,
    input  logic                 single_shot,
    input  logic                 cap_vsync,
    input  logic                 cap_we,
    input  logic [ADDRW-1:0]     cap_addr,
    output logic [NUM_BANKS-1:0] bank_we,
    output logic [NUM_BANKS-1:0] wr_bank,
    output logic [NUM_BANKS-1:0] disp_bank,
    output logic                 disp_valid,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [ADDRW-1:0]     pix_cnt,
    output logic [FCNT_W-1:0]    frame_cnt,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, COMMIT} state_t;
    localparam logic [ADDRW-1:0] FP = ADDRW'(FRAME_PIXELS);
    state_t state_q, state_d;
    logic [NUM_BANKS-1:0] wr_bank_q, wr_bank_d, disp_bank_q, disp_bank_d;
    logic disp_valid_q, disp_valid_d, frame_done_q, frame_done_d, frame_err_q, frame_err_d;
    logic [ADDRW-1:0] pix_cnt_q, pix_cnt_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic vsync_q, ss_latch_q, ss_latch_d, addr_ok_q, addr_ok_d;
    logic vs_fall, vs_rise, full, accept;
    assign vs_fall = vsync_q & ~cap_vsync;
    assign vs_rise = ~vsync_q & cap_vsync;
    assign full    = pix_cnt_q >= FP;
    // Combinational so the RAM strobe lines up with cap_addr and pixel data
    assign accept  = (state_q == ACTIVE) && cap_we && !full;
    assign bank_we    = accept ? wr_bank_q : '0;
    assign wr_bank    = wr_bank_q;
    assign disp_bank  = disp_bank_q;
    assign disp_valid = disp_valid_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign pix_cnt    = pix_cnt_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = state_q != IDLE;
    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        disp_bank_d  = disp_bank_q;
        disp_valid_d = disp_valid_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        pix_cnt_d    = pix_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        ss_latch_d   = ss_latch_q;
        addr_ok_d    = addr_ok_q;
        case (state_q)
            IDLE: begin
                ss_latch_d = ss_latch_q | single_shot;
                if (en) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                ss_latch_d = ss_latch_q | single_shot;
                if (!en) state_d = IDLE;
                else if (vs_fall) begin
                    state_d   = ACTIVE;
                    pix_cnt_d = '0;
                    addr_ok_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (cap_we && full) addr_ok_d = 1'b0;
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (cap_addr != pix_cnt_q) addr_ok_d = 1'b0;
                end
                // Judge the frame including a write accepted on the vs_rise cycle itself
                if (vs_rise) begin
                    if (pix_cnt_d == FP && addr_ok_d) state_d = COMMIT;
                    else begin
                        frame_err_d = 1'b1;
                        state_d     = (!en || ss_latch_q) ? IDLE : WAIT_VS;
                    end
                end
            end
            COMMIT: begin
                disp_bank_d  = wr_bank_q;
                disp_valid_d = 1'b1;
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 1'b1;
                wr_bank_d    = {wr_bank_q[NUM_BANKS-2:0], wr_bank_q[NUM_BANKS-1]};
                ss_latch_d   = 1'b0;
                state_d      = (ss_latch_q || !en) ? IDLE : WAIT_VS;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge cap_pclk) begin
        if (cap_rst) begin
            state_q      <= IDLE;
            wr_bank_q    <= NUM_BANKS'(1);
            disp_bank_q  <= '0;
            disp_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            pix_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            vsync_q      <= 1'b1;
            ss_latch_q   <= 1'b0;
            addr_ok_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            disp_bank_q  <= disp_bank_d;
            disp_valid_q <= disp_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            vsync_q      <= cap_vsync;
            ss_latch_q   <= ss_latch_d;
            addr_ok_q    <= addr_ok_d;
        end
    end
endmodule

// File: tb/tb_cap_bank_sched.sv
// tb_cap_bank_sched: randomized frames against an integer-level model of the bank scheduler,
// with a short frame length so many complete frames fit in the run.
module tb_cap_bank_sched;
    localparam int NB = 4;
    localparam int FP = 40;
    localparam int AW = 17;
    localparam int FW = 8;
    localparam int S_I = 0, S_W = 1, S_A = 2, S_C = 3;
    logic cap_pclk = 1'b0, cap_rst, en, single_shot, cap_vsync, cap_we;
    logic [AW-1:0] cap_addr;
    logic [NB-1:0] bank_we, wr_bank, disp_bank;
    logic disp_valid, frame_done, frame_err, busy;
    logic [AW-1:0] pix_cnt;
    logic [FW-1:0] frame_cnt;
    int n_cmp = 0, n_bad = 0, ndone = 0, nerr = 0;
    int m_st, m_wb, m_db, m_pc, m_fc;
    bit m_dv, m_fd, m_fe, m_vs, m_ss, m_ok, armed = 0, fall, rise;

    cap_bank_sched #(.NUM_BANKS(NB), .FRAME_PIXELS(FP), .ADDRW(AW), .FCNT_W(FW)) dut (
        .cap_pclk(cap_pclk), .cap_rst(cap_rst), .en(en), .single_shot(single_shot),
        .cap_vsync(cap_vsync), .cap_we(cap_we), .cap_addr(cap_addr), .bank_we(bank_we),
        .wr_bank(wr_bank), .disp_bank(disp_bank), .disp_valid(disp_valid),
        .frame_done(frame_done), .frame_err(frame_err), .pix_cnt(pix_cnt),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 cap_pclk = ~cap_pclk;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cap_pclk);
        #2;
    endtask

    // Bank held as an index and display as index-or-none; one-hot only when compared
    task automatic model_loop();
        forever begin
            @(posedge cap_pclk);
            if (cap_rst) begin
                m_st = S_I; m_wb = 0; m_db = -1; m_dv = 0; m_fd = 0; m_fe = 0;
                m_pc = 0; m_fc = 0; m_vs = 1; m_ss = 0; m_ok = 1; armed = 1;
            end else begin
                fall = m_vs && !cap_vsync;
                rise = !m_vs && cap_vsync;
                m_fd = 0; m_fe = 0;
                if (m_st == S_I) begin
                    if (single_shot) m_ss = 1;
                    if (en) m_st = S_W;
                end else if (m_st == S_W) begin
                    if (single_shot) m_ss = 1;
                    if (!en) m_st = S_I;
                    else if (fall) begin m_st = S_A; m_pc = 0; m_ok = 1; end
                end else if (m_st == S_A) begin
                    if (cap_we && m_pc < FP) begin
                        if (32'(cap_addr) != m_pc) m_ok = 0;
                        m_pc++;
                    end else if (cap_we) m_ok = 0;
                    if (rise) begin
                        if (m_pc == FP && m_ok) m_st = S_C;
                        else begin m_fe = 1; m_st = (!en || m_ss) ? S_I : S_W; end
                    end
                end else begin
                    m_db = m_wb; m_dv = 1; m_fd = 1;
                    m_fc = (m_fc + 1) % 256;
                    m_wb = (m_wb + 1) % NB;
                    m_st = (m_ss || !en) ? S_I : S_W;
                    m_ss = 0;
                end
                m_vs = cap_vsync;
            end
        end
    endtask

    task automatic compare_loop();
        int exp_we;
        forever begin
            @(negedge cap_pclk);
            if (armed) begin
                exp_we = (m_st == S_A && cap_we && m_pc < FP) ? (1 << m_wb) : 0;
                chk("bank_we", 32'(bank_we), exp_we);
                chk("wr_bank", 32'(wr_bank), 1 << m_wb);
                chk("disp_bank", 32'(disp_bank), m_db < 0 ? 0 : 1 << m_db);
                chk("disp_valid", 32'(disp_valid), 32'(m_dv));
                chk("frame_done", 32'(frame_done), 32'(m_fd));
                chk("frame_err", 32'(frame_err), 32'(m_fe));
                chk("pix_cnt", 32'(pix_cnt), m_pc);
                chk("frame_cnt", 32'(frame_cnt), m_fc);
                chk("busy", 32'(busy), 32'(m_st != S_I));
                if (bank_we != 0) chk("we_vs_disp", 32'(bank_we == disp_bank), 0);
                if (frame_done) ndone++;
                if (frame_err) nerr++;
            end
        end
    endtask

    // Expects WAIT_VS with vsync high; bad_at > 0 repeats the previous address there
    task automatic frame(input int n, input int bad_at, input bit gaps, input bit drop_en);
        cap_vsync = 0;
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            if (gaps) while ($urandom_range(3) == 0) begin cap_we = 0; tick(); end
            cap_we = 1;
            cap_addr = AW'((bad_at > 0 && i == bad_at) ? i - 1 : i);
            if (drop_en && i == 1) en = 0;
            tick();
        end
        cap_we = 0;
        cap_vsync = 1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        int d0, e0, f0, n, bad;
        cap_rst = 1; en = 0; single_shot = 0; cap_vsync = 1; cap_we = 0; cap_addr = '0;
        fork
            model_loop();
            compare_loop();
        join_none
        tick();
        tick();
        chk("rst_wr_bank", 32'(wr_bank), 1);
        chk("rst_disp_bank", 32'(disp_bank), 0);
        chk("rst_busy", 32'(busy), 0);
        cap_rst = 0;
        en = 1;
        tick();
        tick();
        d0 = ndone;
        frame(FP, -1, 0, 0);
        chk("f1_done", 32'(ndone - d0), 1);
        chk("f1_disp", 32'(disp_bank), 4'b0001);
        chk("f1_wr", 32'(wr_bank), 4'b0010);
        chk("f1_cnt", 32'(frame_cnt), 1);
        for (int k = 1; k < 5; k++) begin
            frame(FP, -1, 0, 0);
            chk("f5_disp", 32'(disp_bank), 1 << (k % 4));
        end
        chk("f5_cnt", 32'(frame_cnt), 5);
        e0 = nerr;
        frame(FP / 2, -1, 0, 0);
        chk("short_err", 32'(nerr - e0), 1);
        chk("short_disp", 32'(disp_bank), 4'b0001);
        chk("short_wr", 32'(wr_bank), 4'b0010);
        frame(FP, -1, 1, 0);
        chk("reuse_disp", 32'(disp_bank), 4'b0010);
        e0 = nerr;
        frame(FP + 10, -1, 0, 0);
        chk("long_err", 32'(nerr - e0), 1);
        chk("long_pix", 32'(pix_cnt), FP);
        e0 = nerr;
        frame(FP, 5, 0, 0);
        chk("dup_err", 32'(nerr - e0), 1);
        chk("dup_disp", 32'(disp_bank), 4'b0010);
        en = 0;
        tick();
        tick();
        single_shot = 1;
        tick();
        single_shot = 0;
        en = 1;
        tick();
        tick();
        d0 = ndone;
        f0 = int'(frame_cnt);
        frame(FP, -1, 0, 1);
        frame(FP, -1, 0, 0);
        chk("ss_done", 32'(ndone - d0), 1);
        chk("ss_busy", 32'(busy), 0);
        chk("ss_cnt", 32'(frame_cnt), (f0 + 1) % 256);
        en = 1;
        tick();
        tick();
        cap_vsync = 0;
        tick();
        tick();
        for (int i = 0; i < FP / 2; i++) begin cap_we = 1; cap_addr = AW'(i); tick(); end
        cap_rst = 1;
        tick();
        chk("mid_rst_valid", 32'(disp_valid), 0);
        chk("mid_rst_wr", 32'(wr_bank), 1);
        chk("mid_rst_pix", 32'(pix_cnt), 0);
        chk("mid_rst_fcnt", 32'(frame_cnt), 0);
        cap_rst = 0;
        cap_we = 0;
        cap_vsync = 1;
        tick();
        tick();
        tick();
        frame(FP, -1, 0, 0);
        chk("post_rst_disp", 32'(disp_bank), 4'b0001);
        for (int f = 0; f < 40; f++) begin
            en = ($urandom_range(7) != 0);
            if ($urandom_range(5) == 0) begin single_shot = 1; tick(); single_shot = 0; end
            en = en | ($urandom_range(3) != 0);
            tick();
            tick();
            n = ($urandom_range(2) == 0) ? FP - 3 + int'($urandom_range(6)) : FP;
            bad = ($urandom_range(5) == 0) ? int'($urandom_range(FP - 2)) + 1 : -1;
            frame(n, bad, 1, $urandom_range(9) == 0);
            if ($urandom_range(15) == 0) begin cap_rst = 1; tick(); cap_rst = 0; end
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
